// File: rtl/hs_pkg.sv
// Shared definitions for the high-score RAM sequencer slice.
//   HS_AW / HS_LW        : default RAM address and burst length widths.
//   HS_SETTLE_DEF        : default pause-to-first-access settle time (cycles).
//   HS_RAM_LAT_DEF       : default RAM read latency (cycles).
//   hs_seq_state_t       : sequencer FSM state encoding.
package hs_pkg;

  localparam int HS_AW          = 16;
  localparam int HS_LW          = 8;
  localparam int HS_SETTLE_DEF  = 4;
  localparam int HS_RAM_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VB,
    S_SETTLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RELEASE
  } hs_seq_state_t;

endpackage

// File: rtl/hs_ram_sequencer_if.sv
// Request / byte-stream bus between the hiscore engine (master) and the
// RAM sequencer (slave).
//   req_*      : one burst request (write flag, start address, length).
//   abort      : terminate the burst in progress.
//   wr_*       : bytes to write into RAM (valid/ready).
//   rd_*       : bytes read from RAM (one-cycle valid pulse).
//   done       : one-cycle end-of-burst pulse, qualified by aborted.
interface hs_ram_sequencer_if
  import hs_pkg::*;
#(
  parameter int AW = HS_AW,
  parameter int LW = HS_LW
);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          abort;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          done;
  logic          aborted;

  modport master (
    output req_valid, req_write, req_addr, req_len, abort, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, done, aborted
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, abort, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, done, aborted
  );

endinterface

// File: rtl/hs_edge_det.sv
// Registered rising-edge detector.
//   clk, reset : clock and synchronous active-high reset.
//   sig        : level input, synchronous to clk.
//   rise       : high in the cycle where sig is 1 and was 0 the cycle before.
// A level that is already high produces no edge until it falls and rises again.
module hs_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/hs_ram_sequencer.sv
// High-score save/restore burst sequencer for game work RAM.
//   clk, reset     : system clock, synchronous active-high reset.
//   vblank         : vertical blank; optionally gates the burst start.
//   bus (slave)    : request, abort, write-byte and read-byte streams.
//   pause_cpu      : CPU pause request, held from settle to release.
//   ram_access     : sequencer owns the shared RAM port.
//   ram_address    : RAM address.
//   data_to_ram    : write data, registered together with ram_write.
//   ram_write      : RAM write strobe.
//   data_from_ram  : RAM read data, valid RAM_LAT cycles after the address.
module hs_ram_sequencer
  import hs_pkg::*;
#(
  parameter int AW          = HS_AW,
  parameter int LW          = HS_LW,
  parameter int RAM_LAT     = HS_RAM_LAT_DEF,
  parameter int SETTLE      = HS_SETTLE_DEF,
  parameter bit SYNC_VBLANK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vblank,
  hs_ram_sequencer_if.slave   bus,
  output logic                pause_cpu,
  output logic                ram_access,
  output logic [AW-1:0]       ram_address,
  output logic [7:0]          data_to_ram,
  output logic                ram_write,
  input  logic [7:0]          data_from_ram
);

  hs_seq_state_t state_q, state_d;

  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] cnt_q;
  logic [7:0]    tmr_q;
  logic          aborted_q;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;

  logic          vb_rise;
  logic          busy;
  logic          abort_take;
  logic          settle_done;
  logic          rd_sample;
  logic          wr_take;

  logic          req_ready_c;
  logic          wr_ready_c;
  logic          done_c;
  logic          aborted_c;

  hs_edge_det u_vb_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (vblank),
    .rise  (vb_rise)
  );

  // Abort only has meaning while a burst is actually in flight.
  assign busy        = (state_q != S_IDLE) && (state_q != S_RELEASE);
  assign abort_take  = busy && bus.abort;
  assign settle_done = (state_q == S_SETTLE) && (tmr_q == 8'd0);
  assign rd_sample   = (state_q == S_RD_WAIT) && (tmr_q == 8'd0) && !bus.abort;
  assign wr_take     = wr_ready_c && bus.wr_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_len == '0)    state_d = S_RELEASE;
          else if (SYNC_VBLANK)     state_d = S_WAIT_VB;
          else                      state_d = S_SETTLE;
        end
      end
      S_WAIT_VB:  if (vb_rise) state_d = S_SETTLE;
      S_SETTLE:   if (tmr_q == 8'd0) state_d = write_q ? S_WRITE : S_RD_ISSUE;
      // Count reaching zero means the final strobe is on the port this
      // cycle; leave only after it has been presented.
      S_WRITE:    if (cnt_q == '0) state_d = S_RELEASE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (tmr_q == 8'd0) state_d = (cnt_q == LW'(1)) ? S_RELEASE : S_RD_ISSUE;
      end
      S_RELEASE:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort_take) state_d = S_RELEASE;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready_c = 1'b0;
    wr_ready_c  = 1'b0;
    done_c      = 1'b0;
    aborted_c   = 1'b0;
    pause_cpu   = 1'b0;
    ram_access  = 1'b0;
    unique case (state_q)
      S_IDLE:   req_ready_c = 1'b1;
      S_SETTLE: pause_cpu   = 1'b1;
      S_WRITE: begin
        pause_cpu  = 1'b1;
        ram_access = 1'b1;
        // No new byte on the abort cycle, so nothing is strobed in RELEASE.
        wr_ready_c = (cnt_q != '0) && !bus.abort;
      end
      S_RD_ISSUE, S_RD_WAIT: begin
        pause_cpu  = 1'b1;
        ram_access = 1'b1;
      end
      S_RELEASE: begin
        done_c    = 1'b1;
        aborted_c = aborted_q;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.wr_ready  = wr_ready_c;
  assign bus.done      = done_c;
  assign bus.aborted   = aborted_c;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // ---------------------------------------------------------------------------
  // Datapath: request latch, counters, RAM port registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      tmr_q       <= 8'd0;
      aborted_q   <= 1'b0;
      ram_address <= '0;
      data_to_ram <= 8'd0;
      ram_write   <= 1'b0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      ram_write  <= wr_take;
      rd_valid_q <= rd_sample;

      if (state_q == S_IDLE && bus.req_valid) begin
        write_q   <= bus.req_write;
        addr_q    <= bus.req_addr;
        cnt_q     <= bus.req_len;
        aborted_q <= 1'b0;
      end

      if (abort_take) aborted_q <= 1'b1;

      // Shared timer: settle countdown, then per-byte read latency.
      unique case (state_q)
        S_SETTLE, S_RD_WAIT: if (tmr_q != 8'd0) tmr_q <= tmr_q - 8'd1;
        S_RD_ISSUE:          tmr_q <= 8'(RAM_LAT - 1);
        default:             tmr_q <= 8'(SETTLE - 1);
      endcase

      if (settle_done && !bus.abort) ram_address <= addr_q;

      // A write advances the address once its strobe has been presented,
      // so data and address appear on the port together.
      if (wr_take) begin
        data_to_ram <= bus.wr_data;
        cnt_q       <= cnt_q - LW'(1);
      end
      if (ram_write) ram_address <= ram_address + AW'(1);

      if (rd_sample) begin
        rd_data_q   <= data_from_ram;
        ram_address <= ram_address + AW'(1);
        cnt_q       <= cnt_q - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hs_ram_sequencer.sv
module tb_hs_ram_sequencer;
  import hs_pkg::*;

  localparam int AW      = 16;
  localparam int LW      = 8;
  localparam int RAM_LAT = 2;
  localparam int SETTLE  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Free-run DUT (SYNC_VBLANK=0) and vblank-synchronised DUT.
  hs_ram_sequencer_if #(.AW(AW), .LW(LW)) bus0 ();
  hs_ram_sequencer_if #(.AW(AW), .LW(LW)) bus1 ();

  logic          vblank0, vblank1;
  logic          pause0, access0, ram_write0;
  logic          pause1, access1, ram_write1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    dto0, dto1, dfr0, dfr1;

  hs_ram_sequencer #(.AW(AW), .LW(LW), .RAM_LAT(RAM_LAT), .SETTLE(SETTLE),
                     .SYNC_VBLANK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .vblank(vblank0), .bus(bus0),
    .pause_cpu(pause0), .ram_access(access0), .ram_address(addr0),
    .data_to_ram(dto0), .ram_write(ram_write0), .data_from_ram(dfr0)
  );

  hs_ram_sequencer #(.AW(AW), .LW(LW), .RAM_LAT(RAM_LAT), .SETTLE(SETTLE),
                     .SYNC_VBLANK(1'b1)) dut1 (
    .clk(clk), .reset(reset), .vblank(vblank1), .bus(bus1),
    .pause_cpu(pause1), .ram_access(access1), .ram_address(addr1),
    .data_to_ram(dto1), .ram_write(ram_write1), .data_from_ram(dfr1)
  );

  // RAM read model: contents are a fixed function of address, data appears
  // RAM_LAT cycles after the address.
  function automatic logic [7:0] ram_val(input logic [15:0] a);
    if (a == 16'h8010)      ram_val = 8'h55;
    else if (a == 16'h8011) ram_val = 8'h66;
    else                    ram_val = a[7:0] ^ 8'hA5;
  endfunction

  logic [7:0] pipe0 [0:RAM_LAT-1];
  always @(posedge clk) begin
    pipe0[0] <= ram_val(addr0);
    for (int i = 1; i < RAM_LAT; i++) pipe0[i] <= pipe0[i-1];
  end
  assign dfr0 = pipe0[RAM_LAT-1];
  assign dfr1 = 8'h00;

  // Scoreboard
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  wr_exp_t    wq[$];
  logic [7:0] rq[$];
  logic       dq[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_wr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever dut0 presents a strobe/pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_write0) begin
        n_wr_seen++;
        check("write_expected", 32'(wq.size() != 0), 32'd1);
        check("write_owns_port", {access0, pause0}, 2'b11);
        if (wq.size() != 0) begin
          wr_exp_t e;
          e = wq.pop_front();
          check("write_addr", addr0, e.addr);
          check("write_data", dto0, e.data);
        end
      end
      if (bus0.rd_valid) begin
        check("read_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) check("read_data", bus0.rd_data, rq.pop_front());
      end
      if (bus0.done) begin
        check("done_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) check("aborted_flag", bus0.aborted, dq.pop_front());
      end
    end
  end

  task automatic issue0(input logic wr, input logic [15:0] a, input logic [7:0] len);
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = a;
    bus0.req_len   = len;
    check("req_ready_at_accept", bus0.req_ready, 1'b1);
    step();
    bus0.req_valid = 1'b0;
  endtask

  task automatic wait_done0(input string name, input int lim);
    int k;
    k = 0;
    while (!bus0.done && k < lim) begin
      step();
      k++;
    end
    check(name, bus0.done, 1'b1);
    step();
  endtask

  task automatic wait_wr_ready0(input string name);
    int k;
    k = 0;
    while (!bus0.wr_ready && k < 30) begin
      step();
      k++;
    end
    check(name, bus0.wr_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] wbytes [0:2];
    int n, idx, first, second, cnt;
    logic took;

    reset = 1'b1;
    vblank0 = 1'b0; vblank1 = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_len = '0;
    bus0.abort = 1'b0; bus0.wr_data = 8'h00; bus0.wr_valid = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_len = '0;
    bus1.abort = 1'b0; bus1.wr_data = 8'h00; bus1.wr_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_req_ready", bus0.req_ready, 1'b1);
    check("rst_pause", pause0, 1'b0);
    check("rst_access", access0, 1'b0);
    check("rst_ram_write", ram_write0, 1'b0);
    check("rst_ram_address", addr0, 16'h0000);
    check("rst_rd_data", bus0.rd_data, 8'h00);
    check("rst_done", bus0.done, 1'b0);
    check("rst_req_ready_vb", bus1.req_ready, 1'b1);

    // Write burst 8000, 3 bytes, wr_valid held high
    wbytes[0] = 8'hAA; wbytes[1] = 8'hBB; wbytes[2] = 8'hCC;
    wq.push_back({16'h8000, 8'hAA});
    wq.push_back({16'h8001, 8'hBB});
    wq.push_back({16'h8002, 8'hCC});
    dq.push_back(1'b0);
    check("pause_before_accept", pause0, 1'b0);
    issue0(1'b1, 16'h8000, 8'd3);
    check("pause_1_after_accept", pause0, 1'b1);
    n = 0;
    while (!access0 && n < 20) begin
      step();
      n++;
    end
    check("settle_cycles", n, 4);
    idx = 0;
    for (int t = 0; t < 20 && idx < 3; t++) begin
      bus0.wr_valid = 1'b1;
      bus0.wr_data  = wbytes[idx];
      took = bus0.wr_ready;
      step();
      if (took) idx++;
    end
    bus0.wr_valid = 1'b0;
    check("write_bytes_taken", idx, 3);
    wait_done0("write_done", 20);

    // Read burst 8010, 2 bytes: 55 then 66, three cycles apart
    rq.push_back(8'h55);
    rq.push_back(8'h66);
    dq.push_back(1'b0);
    n = n_wr_seen;
    issue0(1'b0, 16'h8010, 8'd2);
    first = -1; second = -1;
    for (int t = 0; t < 40; t++) begin
      if (bus0.rd_valid) begin
        if (first < 0) first = t;
        else           second = t;
      end
      if (bus0.done) break;
      step();
    end
    check("rd_valid_spacing", second - first, 3);
    check("read_done", bus0.done, 1'b1);
    step();
    check("no_write_in_read", n_wr_seen - n, 0);

    // vblank-synchronised start: request while vblank is already high
    vblank1 = 1'b1;
    step();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0;
    bus1.req_addr = 16'h0040; bus1.req_len = 8'd1;
    step();
    bus1.req_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      check("vb_pause_low_high_level", pause1, 1'b0);
      step();
    end
    vblank1 = 1'b0;
    step(); step();
    check("vb_pause_low_after_fall", pause1, 1'b0);
    vblank1 = 1'b1;
    check("vb_pause_low_at_rise", pause1, 1'b0);
    step();
    check("vb_pause_after_rise", pause1, 1'b1);
    n = 0;
    while (!bus1.done && n < 30) begin
      step();
      n++;
    end
    check("vb_burst_done", bus1.done, 1'b1);
    step();

    // Address wrap with a five-cycle stall between the two bytes
    wq.push_back({16'hFFFF, 8'h11});
    wq.push_back({16'h0000, 8'h22});
    dq.push_back(1'b0);
    issue0(1'b1, 16'hFFFF, 8'd2);
    wait_wr_ready0("wrap_wr_ready");
    bus0.wr_valid = 1'b1; bus0.wr_data = 8'h11;
    step();
    bus0.wr_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      check("stall_wr_ready", bus0.wr_ready, 1'b1);
      check("stall_pause", pause0, 1'b1);
      step();
    end
    bus0.wr_valid = 1'b1; bus0.wr_data = 8'h22;
    check("wrap_second_ready", bus0.wr_ready, 1'b1);
    step();
    bus0.wr_valid = 1'b0;
    wait_done0("wrap_done", 20);

    // Abort during the read of byte 3 of 10 (8100 -> A5, 8101 -> A4)
    rq.push_back(8'hA5);
    rq.push_back(8'hA4);
    dq.push_back(1'b1);
    issue0(1'b0, 16'h8100, 8'd10);
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      if (bus0.rd_valid) cnt++;
      if (cnt == 2) break;
      step();
    end
    check("reads_before_abort", cnt, 2);
    step();
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    n = 0;
    while (!bus0.done && n < 1) begin
      step();
      n++;
    end
    check("abort_done", bus0.done, 1'b1);
    check("abort_aborted", bus0.aborted, 1'b1);
    check("abort_pause_low", pause0, 1'b0);
    check("abort_access_low", access0, 1'b0);
    step();

    // New zero-length request in the first IDLE cycle, with abort asserted
    // alongside it: must still be accepted, done follows, no pause.
    dq.push_back(1'b0);
    bus0.abort = 1'b1;
    issue0(1'b1, 16'h1234, 8'd0);
    bus0.abort = 1'b0;
    n = 0;
    while (!bus0.done && n < 1) begin
      check("len0_pause_low", pause0, 1'b0);
      step();
      n++;
    end
    check("len0_done", bus0.done, 1'b1);
    check("len0_pause_at_done", pause0, 1'b0);
    step();
    check("len0_pause_after", pause0, 1'b0);

    // Synchronous reset in the middle of a stalled write burst
    issue0(1'b1, 16'h9000, 8'd4);
    wait_wr_ready0("rstmid_wr_ready");
    check("rstmid_pause_before", pause0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_pause", pause0, 1'b0);
    check("rstmid_access", access0, 1'b0);
    check("rstmid_ram_write", ram_write0, 1'b0);
    check("rstmid_ram_address", addr0, 16'h0000);
    check("rstmid_data_to_ram", dto0, 8'h00);
    check("rstmid_rd_data", bus0.rd_data, 8'h00);
    check("rstmid_wr_ready", bus0.wr_ready, 1'b0);
    check("rstmid_done", bus0.done, 1'b0);
    check("rstmid_req_ready", bus0.req_ready, 1'b1);
    repeat (4) step();

    check("pending_writes", wq.size(), 0);
    check("pending_reads", rq.size(), 0);
    check("pending_dones", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
